inc_pulse_gen: RTL and testbench
================================

INC_PULSE_GEN -- requirements
Module: inc_pulse_gen

Interface
REQ-001 The block SHALL have parameter CNT_W, default 4, giving the width of the pulse-count command.
REQ-002 The block SHALL have parameter GAP_CYCLES, default 1, giving the number of low cycles after each pulse; legal range is 1..15.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state SHALL change on rising clk only.
REQ-004 The block SHALL have port rst, input, 1 bit, the asynchronous active-high reset.
REQ-005 The block SHALL have port cmd_valid, input, 1 bit, which presents a command.
REQ-006 The block SHALL have port cmd_count, input, CNT_W bits, the number of increment pulses requested.
REQ-007 The block SHALL have port cmd_ready, output, 1 bit, which means a command can be accepted.
REQ-008 The block SHALL have port abort, input, 1 bit, a synchronous cancel of the command in progress.
REQ-009 The block SHALL have port inc_out, output, 1 bit, the increment-request line that drives a pulse counter's test_inc input.
REQ-010 The block SHALL have port busy, output, 1 bit, which is high while a command is in progress.
REQ-011 The block SHALL have port done, output, 1 bit, a one-cycle completion strobe.
REQ-012 The block SHALL have port pulses_left, output, CNT_W bits, the number of pulses still to be issued.
REQ-013 The block SHALL have port exp_val, output, 2 bits, the value the receiving 2-bit counter is expected to hold.

Function
REQ-014 The block SHALL have the states IDLE, PULSE, GAP and DONE, and every output SHALL be registered.
REQ-015 cmd_ready SHALL equal (state==IDLE); a command SHALL be accepted on a rising edge where cmd_valid and cmd_ready are both high.
REQ-016 On acceptance with cmd_count!=0, the block SHALL load pulses_left with cmd_count and move to PULSE.
REQ-017 On acceptance with cmd_count==0, the block SHALL move directly to DONE and issue no pulse.
REQ-018 inc_out SHALL be high exactly while in PULSE, which SHALL last one cycle; on leaving PULSE, pulses_left SHALL decrement by 1 and the state SHALL become GAP.
REQ-019 GAP SHALL last exactly GAP_CYCLES cycles with inc_out low, then go to PULSE if pulses_left!=0, else to DONE.
REQ-020 With GAP_CYCLES=G, the pulse period SHALL be 1+G cycles, and the first pulse SHALL start on the edge of acceptance (zero added latency).
REQ-021 done SHALL be high exactly one cycle, during DONE; the next state SHALL be IDLE.
REQ-022 busy SHALL be high in PULSE, GAP and DONE.
REQ-023 exp_val SHALL increment by 1 modulo 4 on each edge that leaves PULSE, so 3 wraps to 0; it SHALL not reset between commands.
REQ-024 cmd_valid SHALL be ignored outside IDLE, and cmd_count SHALL be sampled only at acceptance.
REQ-025 abort high in PULSE or GAP SHALL force IDLE on the next edge, with inc_out=0, pulses_left=0 and no done strobe.
REQ-026 If abort is high in PULSE, that pulse SHALL still count in exp_val, since the pulse was emitted.
REQ-027 abort SHALL be ignored in IDLE and DONE; abort and cmd_valid both high in IDLE SHALL accept the command.
REQ-028 With cmd_count at its maximum (2^CNT_W-1), the block SHALL issue all pulses with no counter overflow.

Reset
REQ-029 rst high SHALL immediately set state=IDLE, inc_out=0, busy=0, done=0, pulses_left=0 and exp_val=0, regardless of clk.
REQ-030 rst asserted mid-command SHALL drop any pulse in progress at once, without waiting for a clock edge.
REQ-031 After rst deasserts, the first command SHALL be acceptable on the first rising edge.

Verification
REQ-032 A bench SHALL cover the basic command: with GAP_CYCLES=1, accept cmd_count=3 at edge E0 -> inc_out high E0-E1, E2-E3 and E4-E5; done high E6-E7; cmd_ready high after E7; exp_val=3.
REQ-033 A bench SHALL cover exp_val wrap-around: from exp_val=3, a cmd_count=2 command -> exp_val 0 after the first pulse and 1 after the second.
REQ-034 A bench SHALL cover the zero-count command: cmd_count=0 -> no inc_out pulse; done high the cycle after acceptance; pulses_left stays 0.
REQ-035 A bench SHALL cover abort: cmd_count=5, abort during the second GAP -> inc_out stays low, IDLE next edge, no done, exp_val advanced by exactly 2.
REQ-036 A bench SHALL cover asynchronous reset mid-pulse: rst raised mid-cycle while inc_out=1 -> inc_out, busy and exp_val are 0 before the next clk edge.
REQ-037 A bench SHALL cover loopback: inc_out driven into a 2-bit pulse counter, cmd_count=15 with GAP_CYCLES=1 and then GAP_CYCLES=3 -> the counter output equals exp_val after every pulse, with no missed increments.

Source files
------------

// File: rtl/inc_pulse_gen.sv
// Increment-pulse generator: issues cmd_count single-cycle pulses on inc_out,
// each followed by GAP_CYCLES low cycles, and tracks the expected 2-bit counter value.
module inc_pulse_gen #(
  parameter int CNT_W      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             cmd_ready,
  input  logic             abort,
  output logic             inc_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] pulses_left,
  output logic [1:0]       exp_val
);

  typedef enum logic [1:0] {IDLE, PULSE, GAP, DONE} state_e;

  // The gap counter is loaded with GAP_CYCLES-1 so that GAP lasts exactly GAP_CYCLES cycles.
  localparam logic [3:0] GapLoad = 4'(GAP_CYCLES - 1);

  state_e           state_q, state_d;
  logic [3:0]       gapCnt_q, gapCnt_d;
  logic [CNT_W-1:0] pulsesLeft_q, pulsesLeft_d;
  logic [1:0]       expVal_q, expVal_d;
  logic             incOut_q, incOut_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ready_q, ready_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      gapCnt_q     <= '0;
      pulsesLeft_q <= '0;
      expVal_q     <= '0;
      incOut_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      gapCnt_q     <= gapCnt_d;
      pulsesLeft_q <= pulsesLeft_d;
      expVal_q     <= expVal_d;
      incOut_q     <= incOut_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      ready_q      <= ready_d;
    end
  end

  // exp_val advances on every exit from PULSE, aborted or not, since the pulse was already emitted.
  always_comb begin
    state_d      = state_q;
    gapCnt_d     = gapCnt_q;
    pulsesLeft_d = pulsesLeft_q;
    expVal_d     = expVal_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          pulsesLeft_d = cmd_count;
          state_d      = (cmd_count == '0) ? DONE : PULSE;
        end
      end
      PULSE: begin
        expVal_d = expVal_q + 2'd1;
        if (abort) begin
          pulsesLeft_d = '0;
          state_d      = IDLE;
        end else begin
          pulsesLeft_d = pulsesLeft_q - CNT_W'(1);
          gapCnt_d     = GapLoad;
          state_d      = GAP;
        end
      end
      GAP: begin
        if (abort) begin
          pulsesLeft_d = '0;
          state_d      = IDLE;
        end else if (gapCnt_q == 4'd0) begin
          state_d = (pulsesLeft_q != '0) ? PULSE : DONE;
        end else begin
          gapCnt_d = gapCnt_q - 4'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered alongside it.
  always_comb begin
    incOut_d = (state_d == PULSE);
    busy_d   = (state_d != IDLE);
    done_d   = (state_d == DONE);
    ready_d  = (state_d == IDLE);
  end

  assign cmd_ready   = ready_q;
  assign inc_out     = incOut_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pulses_left = pulsesLeft_q;
  assign exp_val     = expVal_q;

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Bench for inc_pulse_gen: two instances (gap 1 and gap 3) checked every cycle against
// a timeline model of each command, plus a 2-bit loopback counter fed by inc_out.
module tb_inc_pulse_gen;

  localparam int CntW = 4;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      cmdValid = 2'b00;
  logic [1:0]      abortIn = 2'b00;
  logic [CntW-1:0] cmdCount [2];
  logic [1:0]      incOut, busyOut, doneOut, readyOut;
  logic [CntW-1:0] pulsesLeft [2];
  logic [1:0]      expVal [2];
  logic [1:0]      loopCnt [2];

  int checks = 0;
  int errors = 0;
  int cycleNo = 0;
  int gapOf [2] = '{1, 3};
  bit mActive [2];
  int mStart [2];
  int mN [2];
  int mBase [2];

  inc_pulse_gen #(.CNT_W(CntW), .GAP_CYCLES(1)) dutA (
    .clk(clk), .rst(rst), .cmd_valid(cmdValid[0]), .cmd_count(cmdCount[0]),
    .cmd_ready(readyOut[0]), .abort(abortIn[0]), .inc_out(incOut[0]), .busy(busyOut[0]),
    .done(doneOut[0]), .pulses_left(pulsesLeft[0]), .exp_val(expVal[0])
  );

  inc_pulse_gen #(.CNT_W(CntW), .GAP_CYCLES(3)) dutB (
    .clk(clk), .rst(rst), .cmd_valid(cmdValid[1]), .cmd_count(cmdCount[1]),
    .cmd_ready(readyOut[1]), .abort(abortIn[1]), .inc_out(incOut[1]), .busy(busyOut[1]),
    .done(doneOut[1]), .pulses_left(pulsesLeft[1]), .exp_val(expVal[1])
  );

  always #5 clk = ~clk;

  // Receiving 2-bit counters: increment on every clock edge that sees inc_out high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) loopCnt[0] <= 2'd0;
    else if (incOut[0]) loopCnt[0] <= loopCnt[0] + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) loopCnt[1] <= 2'd0;
    else if (incOut[1]) loopCnt[1] <= loopCnt[1] + 2'd1;
  end

  function automatic int ceilDiv(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  task automatic checkValue(input string tag, input int idx, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s dut%0d cycle %0d: observed %0d expected %0d", tag, idx, cycleNo, observed, expected);
      $error("[TB] check %s failed", tag);
    end
  endtask

  // A command of n pulses occupies n*(1+gap) cycles followed by one DONE cycle.
  task automatic modelEdge();
    for (int i = 0; i < 2; i++) begin
      int p, r, total;
      p = 1 + gapOf[i];
      if (rst) begin
        mActive[i] = 1'b0;
        mBase[i] = 0;
      end else if (!mActive[i]) begin
        if (cmdValid[i]) begin
          mActive[i] = 1'b1;
          mStart[i] = cycleNo + 1;
          mN[i] = int'(cmdCount[i]);
        end
      end else begin
        r = cycleNo - mStart[i];
        total = mN[i] * p;
        if (r < total && abortIn[i]) begin
          mBase[i] += ceilDiv(r + 1, p);
          mActive[i] = 1'b0;
        end else if (r >= total) begin
          mBase[i] += mN[i];
          mActive[i] = 1'b0;
        end
      end
    end
    cycleNo++;
  endtask

  task automatic checkOutput();
    for (int i = 0; i < 2; i++) begin
      int p, r, total, eInc, eBusy, eDone, eReady, eLeft, eExp;
      p = 1 + gapOf[i];
      eInc = 0; eBusy = 0; eDone = 0; eReady = 1; eLeft = 0; eExp = mBase[i];
      if (mActive[i]) begin
        r = cycleNo - mStart[i];
        total = mN[i] * p;
        eReady = 0;
        eBusy = 1;
        if (r < total) begin
          eInc = (r % p == 0) ? 1 : 0;
          eLeft = mN[i] - ceilDiv(r, p);
          eExp = mBase[i] + ceilDiv(r, p);
        end else begin
          eDone = 1;
          eExp = mBase[i] + mN[i];
        end
      end
      eExp = eExp % 4;
      checkValue("inc_out", i, int'(incOut[i]), eInc);
      checkValue("busy", i, int'(busyOut[i]), eBusy);
      checkValue("done", i, int'(doneOut[i]), eDone);
      checkValue("cmd_ready", i, int'(readyOut[i]), eReady);
      checkValue("pulses_left", i, int'(pulsesLeft[i]), eLeft);
      checkValue("exp_val", i, int'(expVal[i]), eExp);
      checkValue("loopback", i, int'(loopCnt[i]), eExp);
    end
  endtask

  // Inputs change at the falling edge; outputs are checked at the following falling edge.
  task automatic applyStimulus(input logic [1:0] v, input int c0, input int c1, input logic [1:0] ab);
    cmdValid = v;
    cmdCount[0] = CntW'(c0);
    cmdCount[1] = CntW'(c1);
    abortIn = ab;
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    checkOutput();
  endtask

  task automatic idleCycles(input int n);
    for (int k = 0; k < n; k++) applyStimulus(2'b00, 0, 0, 2'b00);
  endtask

  initial begin
    cmdCount[0] = '0;
    cmdCount[1] = '0;
    for (int i = 0; i < 2; i++) begin
      mActive[i] = 1'b0; mStart[i] = 0; mN[i] = 0; mBase[i] = 0;
    end

    idleCycles(2);
    rst = 1'b0;

    // Basic command, accepted on the first edge after reset release.
    applyStimulus(2'b11, 3, 3, 2'b00);
    idleCycles(16);

    // exp_val wrap from 3.
    applyStimulus(2'b11, 2, 2, 2'b00);
    idleCycles(12);

    // Zero-count command.
    applyStimulus(2'b11, 0, 0, 2'b00);
    idleCycles(3);

    // Abort during the second gap of each instance.
    applyStimulus(2'b11, 5, 5, 2'b00);
    idleCycles(3);
    applyStimulus(2'b00, 0, 0, 2'b01);
    applyStimulus(2'b00, 0, 0, 2'b00);
    applyStimulus(2'b00, 0, 0, 2'b10);
    idleCycles(4);

    // Abort during the second pulse of each instance.
    applyStimulus(2'b11, 4, 4, 2'b00);
    idleCycles(2);
    applyStimulus(2'b00, 0, 0, 2'b01);
    applyStimulus(2'b00, 0, 0, 2'b00);
    applyStimulus(2'b00, 0, 0, 2'b10);
    idleCycles(4);

    // Abort together with cmd_valid in IDLE still accepts.
    applyStimulus(2'b11, 2, 2, 2'b11);
    idleCycles(12);

    // Maximum count, full loopback run on both gap settings.
    applyStimulus(2'b11, 15, 15, 2'b00);
    idleCycles(64);

    // Asynchronous reset while a pulse is high.
    applyStimulus(2'b11, 3, 3, 2'b00);
    #1;
    rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checkValue("rst_inc", i, int'(incOut[i]), 0);
      checkValue("rst_busy", i, int'(busyOut[i]), 0);
      checkValue("rst_exp", i, int'(expVal[i]), 0);
      checkValue("rst_left", i, int'(pulsesLeft[i]), 0);
    end
    applyStimulus(2'b00, 0, 0, 2'b00);
    rst = 1'b0;
    applyStimulus(2'b11, 1, 1, 2'b00);
    idleCycles(8);

    // Randomized commands and aborts.
    for (int k = 0; k < 400; k++) begin
      logic [1:0] v, ab;
      v[0] = ($urandom_range(0, 3) == 0);
      v[1] = ($urandom_range(0, 3) == 0);
      ab[0] = ($urandom_range(0, 9) == 0);
      ab[1] = ($urandom_range(0, 9) == 0);
      applyStimulus(v, int'($urandom_range(0, 6)), int'($urandom_range(0, 6)), ab);
    end
    idleCycles(40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
